calc_controller: RTL and testbench

CALC_CONTROLLER -- requirements
Module: calc_controller

---
 rtl/calc_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_calc_controller.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_controller.sv
// calc_controller: front-panel controller for a two-operand BCD calculator.
// The user keys in two 2-digit operands, picks an operation, then the
// controller waits SETTLE cycles for the external datapath and latches its
// result for display.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   btn_inc, btn_next, btn_eq,       one-cycle button pulses
//   btn_clr
//   one, two, three, four            operand digits (A = one*10+two, B = three*10+four)
//   s1..s5                           operation select: add, sub, mul, div, raw display
//   op1..op4, neg, error             datapath result digits (op1 = LSD) and flags
//   res1..res4, res_neg, res_err,    latched display value and flags
//   res_dp
//   cursor                           digit index under edit
//   state_o                          current state encoding
//   busy                             high while waiting for the datapath
module calc_controller #(
  parameter int unsigned SETTLE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_eq,
  input  logic       btn_clr,
  output logic [3:0] one,
  output logic [3:0] two,
  output logic [3:0] three,
  output logic [3:0] four,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       s4,
  output logic       s5,
  input  logic [3:0] op1,
  input  logic [3:0] op2,
  input  logic [3:0] op3,
  input  logic [3:0] op4,
  input  logic       neg,
  input  logic       error,
  output logic [3:0] res1,
  output logic [3:0] res2,
  output logic [3:0] res3,
  output logic [3:0] res4,
  output logic       res_neg,
  output logic       res_err,
  output logic       res_dp,
  output logic [1:0] cursor,
  output logic [2:0] state_o,
  output logic       busy
);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    SEL_OP  = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4,
    ERR     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cursor_q, cursor_d;
  logic [3:0]  dig_q [4];
  logic [3:0]  dig_d [4];
  logic [1:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  res_q [4];
  logic [3:0]  res_d [4];
  logic        res_neg_q, res_neg_d;
  logic        res_err_q, res_err_d;
  logic        res_dp_q, res_dp_d;
  logic [3:0]  op_in [4];

  assign op_in[0] = op1;
  assign op_in[1] = op2;
  assign op_in[2] = op3;
  assign op_in[3] = op4;

  // Saturating compare keeps a digit inside 0..9 even from an illegal value.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ENTER_A;
      cursor_q  <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      res_neg_q <= 1'b0;
      res_err_q <= 1'b0;
      res_dp_q  <= 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        dig_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      res_neg_q <= res_neg_d;
      res_err_q <= res_err_d;
      res_dp_q  <= res_dp_d;
      for (int unsigned i = 0; i < 4; i++) begin
        dig_q[i] <= dig_d[i];
        res_q[i] <= res_d[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    res_neg_d = res_neg_q;
    res_err_d = res_err_q;
    res_dp_d  = res_dp_q;
    for (int unsigned i = 0; i < 4; i++) begin
      dig_d[i] = dig_q[i];
      res_d[i] = res_q[i];
    end

    // Live preview of the datapath while the user is still editing.
    if (state_q == ENTER_A || state_q == ENTER_B || state_q == SEL_OP) begin
      for (int unsigned i = 0; i < 4; i++) res_d[i] = op_in[i];
      res_dp_d  = 1'b1;
      res_neg_d = 1'b0;
      res_err_d = 1'b0;
    end

    // Within each state the highest-priority button that is meaningful
    // there wins; buttons a state ignores do not mask lower ones.
    if (btn_clr) begin
      state_d   = ENTER_A;
      cursor_d  = '0;
      op_d      = '0;
      res_neg_d = 1'b0;
      res_err_d = 1'b0;
      for (int unsigned i = 0; i < 4; i++) dig_d[i] = '0;
    end else begin
      unique case (state_q)
        ENTER_A: begin
          if (btn_next) begin
            if (cursor_q == 2'd0) begin
              cursor_d = 2'd1;
            end else begin
              cursor_d = 2'd2;
              state_d  = ENTER_B;
            end
          end else if (btn_inc) begin
            dig_d[cursor_q] = bcd_inc(dig_q[cursor_q]);
          end
        end
        ENTER_B: begin
          if (btn_next) begin
            if (cursor_q == 2'd2) cursor_d = 2'd3;
            else                  state_d  = SEL_OP;
          end else if (btn_inc) begin
            dig_d[cursor_q] = bcd_inc(dig_q[cursor_q]);
          end
        end
        SEL_OP: begin
          if (btn_eq) begin
            state_d = EXEC;
            cnt_d   = 4'(SETTLE - 1);
          end else if (btn_inc) begin
            op_d = op_q + 2'd1;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            res_neg_d = neg;
            res_err_d = error;
            res_dp_d  = 1'b0;
            if (error) begin
              state_d = ERR;
              for (int unsigned i = 0; i < 4; i++) res_d[i] = '0;
            end else begin
              state_d = SHOW;
              for (int unsigned i = 0; i < 4; i++) res_d[i] = op_in[i];
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        SHOW: begin
          if (btn_next) begin
            state_d  = ENTER_A;
            cursor_d = '0;
          end
        end
        ERR: ;
        default: state_d = ENTER_A;
      endcase
    end
  end

  always_comb begin
    {s1, s2, s3, s4, s5} = '0;
    if (state_q == ENTER_A || state_q == ENTER_B) begin
      s5 = 1'b1;
    end else begin
      unique case (op_q)
        2'd0: s1 = 1'b1;
        2'd1: s2 = 1'b1;
        2'd2: s3 = 1'b1;
        2'd3: s4 = 1'b1;
        default: ;
      endcase
    end
  end

  assign one     = dig_q[0];
  assign two     = dig_q[1];
  assign three   = dig_q[2];
  assign four    = dig_q[3];
  assign res1    = res_q[0];
  assign res2    = res_q[1];
  assign res3    = res_q[2];
  assign res4    = res_q[3];
  assign res_neg = res_neg_q;
  assign res_err = res_err_q;
  assign res_dp  = res_dp_q;
  assign cursor  = cursor_q;
  assign state_o = state_q;
  assign busy    = (state_q == EXEC);

endmodule

// File: tb/tb_calc_controller.sv
// Bench for calc_controller: a behavioural datapath drives op1..op4/neg/error
// from the operand digits and select lines; expected captured results are
// queued when btn_eq is pressed and popped when the controller leaves EXEC.
module tb_calc_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_inc = 1'b0, btn_next = 1'b0, btn_eq = 1'b0, btn_clr = 1'b0;
  logic [3:0] one, two, three, four;
  logic       s1, s2, s3, s4, s5;
  logic [3:0] op1, op2, op3, op4;
  logic       neg, error;
  logic [3:0] res1, res2, res3, res4;
  logic       res_neg, res_err, res_dp;
  logic [1:0] cursor;
  logic [2:0] state_o;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] digs;   // {res4,res3,res2,res1}
    logic        neg;
    logic        err;
    logic [2:0]  st;
  } exp_t;
  exp_t sb[$];

  calc_controller #(.SETTLE(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_inc(btn_inc), .btn_next(btn_next), .btn_eq(btn_eq), .btn_clr(btn_clr),
    .one(one), .two(two), .three(three), .four(four),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5),
    .op1(op1), .op2(op2), .op3(op3), .op4(op4), .neg(neg), .error(error),
    .res1(res1), .res2(res2), .res3(res3), .res4(res4),
    .res_neg(res_neg), .res_err(res_err), .res_dp(res_dp),
    .cursor(cursor), .state_o(state_o), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural datapath; divide by zero reports error with junk digits.
  int a, b, r, mag;
  always_comb begin
    a = int'(one) * 10 + int'(two);
    b = int'(three) * 10 + int'(four);
    error = 1'b0;
    r = a;
    if (s1) r = a + b;
    else if (s2) r = a - b;
    else if (s3) r = a * b;
    else if (s4) begin
      if (b == 0) error = 1'b1;
      else        r = a / b;
    end
    neg = (r < 0);
    mag = (r < 0) ? -r : r;
    if (error) {op4, op3, op2, op1} = 16'h9999;
    else begin
      op1 = 4'(mag % 10);
      op2 = 4'((mag / 10) % 10);
      op3 = 4'((mag / 100) % 10);
      op4 = 4'((mag / 1000) % 10);
    end
  end

  // b = {clr, eq, next, inc}; returns at the falling edge after the capture edge.
  task automatic press(input logic [3:0] b, input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      {btn_clr, btn_eq, btn_next, btn_inc} = b;
      @(negedge clk);
      {btn_clr, btn_eq, btn_next, btn_inc} = 4'b0000;
    end
  endtask

  // Press eq, count busy cycles, then pop and compare the queued result.
  task automatic run_exec(input string tag);
    int cycles;
    exp_t e;
    exp_t got;
    press(4'b0100);
    cycles = 0;
    while (busy && cycles < 20) begin
      cycles++;
      @(negedge clk);
    end
    n_checks++;
    if (cycles != 3) begin
      n_fail++;
      $display("FAIL %s_busy_cycles: got %0d expected 3", tag, cycles);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
    end else begin
      e = sb.pop_front();
      got = {res4, res3, res2, res1, res_neg, res_err, state_o};
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s_result: got digs=%h neg=%b err=%b st=%0d expected digs=%h neg=%b err=%b st=%0d",
                 tag, got.digs, got.neg, got.err, got.st, e.digs, e.neg, e.err, e.st);
      end
    end
    n_checks++;
    if (res_dp !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_res_dp: got %b expected 0", tag, res_dp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({state_o, cursor, one, two, three, four} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_state: got st=%0d cur=%0d digs=%h%h%h%h expected all 0",
               state_o, cursor, one, two, three, four);
    end
    n_checks++;
    if ({res4, res3, res2, res1, res_neg, res_err, res_dp, busy} !== 20'b0000_0000_0000_0000_0010) begin
      n_fail++;
      $display("FAIL reset_res: got res=%h%h%h%h neg=%b err=%b dp=%b busy=%b expected 0 0 0 1 0",
               res4, res3, res2, res1, res_neg, res_err, res_dp, busy);
    end
    n_checks++;
    if ({s1, s2, s3, s4, s5} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_sel: got %b expected 00001", {s1, s2, s3, s4, s5});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_entry;
    press(4'b0001, 1);
    press(4'b0010);
    n_checks++;
    if (cursor !== 2'd1) begin
      n_fail++;
      $display("FAIL entry_cursor: got %0d expected 1", cursor);
    end
    press(4'b0001, 2);
    press(4'b0010);
    n_checks++;
    if (state_o !== 3'd1 || cursor !== 2'd2) begin
      n_fail++;
      $display("FAIL entry_enter_b: got st=%0d cur=%0d expected st=1 cur=2", state_o, cursor);
    end
    press(4'b0001, 3);
    press(4'b0010);
    press(4'b0001, 4);
    press(4'b0010);
    n_checks++;
    if ({one, two, three, four} !== 16'h1234 || state_o !== 3'd2) begin
      n_fail++;
      $display("FAIL entry_digits: got %h%h%h%h st=%0d expected 1234 st=2",
               one, two, three, four, state_o);
    end
    @(negedge clk);
    n_checks++;
    if ({s1, s5} !== 2'b10 || {res4, res3, res2, res1} !== 16'h0046 || res_dp !== 1'b1) begin
      n_fail++;
      $display("FAIL entry_preview: got s1=%b s5=%b res=%h%h%h%h dp=%b expected s1=1 s5=0 res=0046 dp=1",
               s1, s5, res4, res3, res2, res1, res_dp);
    end
  endtask

  task automatic test_add;
    sb.push_back('{digs: 16'h0046, neg: 1'b0, err: 1'b0, st: 3'd4});
    run_exec("add");
  endtask

  task automatic test_show;
    press(4'b0001);
    n_checks++;
    if (state_o !== 3'd4 || {res4, res3, res2, res1} !== 16'h0046) begin
      n_fail++;
      $display("FAIL show_inc_ignored: got st=%0d res=%h%h%h%h expected st=4 res=0046",
               state_o, res4, res3, res2, res1);
    end
    press(4'b0010);
    n_checks++;
    if (state_o !== 3'd0 || cursor !== 2'd0 || {one, two, three, four} !== 16'h1234) begin
      n_fail++;
      $display("FAIL show_next: got st=%0d cur=%0d digs=%h%h%h%h expected st=0 cur=0 digs=1234",
               state_o, cursor, one, two, three, four);
    end
  endtask

  task automatic test_priority;
    press(4'b0011);
    n_checks++;
    if (cursor !== 2'd1 || one !== 4'd1) begin
      n_fail++;
      $display("FAIL prio_next_over_inc: got cur=%0d one=%0d expected cur=1 one=1", cursor, one);
    end
  endtask

  task automatic test_wrap_sub;
    press(4'b1000);
    press(4'b0001, 10);
    n_checks++;
    if (one !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_digit: got %0d expected 0", one);
    end
    press(4'b0010);
    press(4'b0001, 5);
    press(4'b0010);
    press(4'b0001, 1);
    press(4'b0010);
    press(4'b0001, 2);
    press(4'b0010);
    press(4'b0001, 5);
    n_checks++;
    if ({s1, s2, s3, s4, s5} !== 5'b01000) begin
      n_fail++;
      $display("FAIL wrap_op_sub: got %b expected 01000", {s1, s2, s3, s4, s5});
    end
    sb.push_back('{digs: 16'h0007, neg: 1'b1, err: 1'b0, st: 3'd4});
    run_exec("sub");
  endtask

  task automatic test_div_zero;
    press(4'b1000);
    press(4'b0010, 4);
    press(4'b0001, 3);
    n_checks++;
    if (s4 !== 1'b1 || state_o !== 3'd2) begin
      n_fail++;
      $display("FAIL div_select: got s4=%b st=%0d expected s4=1 st=2", s4, state_o);
    end
    sb.push_back('{digs: 16'h0000, neg: 1'b0, err: 1'b1, st: 3'd5});
    run_exec("div0");
    press(4'b0010);
    n_checks++;
    if (state_o !== 3'd5 || res_err !== 1'b1 || {res4, res3, res2, res1} !== 16'h0000) begin
      n_fail++;
      $display("FAIL err_next_ignored: got st=%0d err=%b res=%h%h%h%h expected st=5 err=1 res=0000",
               state_o, res_err, res4, res3, res2, res1);
    end
    press(4'b1000);
    n_checks++;
    if (state_o !== 3'd0 || res_err !== 1'b0 || {one, two, three, four} !== 16'h0000) begin
      n_fail++;
      $display("FAIL err_clr: got st=%0d err=%b digs=%h%h%h%h expected st=0 err=0 digs=0000",
               state_o, res_err, one, two, three, four);
    end
  endtask

  task automatic test_clr_eq;
    press(4'b0010, 4);
    press(4'b1100);
    n_checks++;
    if (state_o !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_eq: got st=%0d busy=%b expected st=0 busy=0", state_o, busy);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (state_o !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_eq_settled: got st=%0d busy=%b expected st=0 busy=0", state_o, busy);
    end
  endtask

  task automatic test_reset_exec;
    press(4'b0010);
    press(4'b0001);
    press(4'b0010, 3);
    @(negedge clk);
    n_checks++;
    if (res1 !== 4'd1 || state_o !== 3'd2) begin
      n_fail++;
      $display("FAIL rexec_preview: got res1=%0d st=%0d expected res1=1 st=2", res1, state_o);
    end
    press(4'b0100);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({state_o, cursor, busy, res_dp, s5, res_err, res_neg} !== 10'b000_00_0_1_1_0_0 ||
        {res4, res3, res2, res1, one, two, three, four} !== 32'h0) begin
      n_fail++;
      $display("FAIL rexec_reset: got st=%0d cur=%0d busy=%b dp=%b s5=%b res=%h%h%h%h digs=%h%h%h%h",
               state_o, cursor, busy, res_dp, s5, res4, res3, res2, res1, one, two, three, four);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (state_o !== 3'd0 || busy !== 1'b0 || res_dp !== 1'b1) begin
      n_fail++;
      $display("FAIL rexec_no_capture: got st=%0d busy=%b dp=%b expected st=0 busy=0 dp=1",
               state_o, busy, res_dp);
    end
  endtask

  initial begin
    test_reset;
    test_entry;
    test_add;
    test_show;
    test_priority;
    test_wrap_sub;
    test_div_zero;
    test_clr_eq;
    test_reset_exec;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
